// File: rtl/axis_accum_adder.sv
// AXI-Stream packet accumulator: sums the low DATA_WIDTH bits of every accepted beat and,
// on tlast, returns a single {overflow, beat_count, sum} result beat addressed to the packet source.
module axis_accum_adder #(
  parameter int          DATA_WIDTH = 128,
  parameter int          CNT_WIDTH  = 16,
  parameter int          AXIS_DATAW = 512,
  parameter int          AXIS_DESTW = 12,
  parameter int          AXIS_USERW = 12,
  parameter int          AXIS_IDW   = 8,
  parameter int unsigned SRC_ADDR   = 0
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic                    axis_in_tvalid,
  output logic                    axis_in_tready,
  input  logic [AXIS_DATAW-1:0]   axis_in_tdata,
  input  logic                    axis_in_tlast,
  input  logic [AXIS_USERW-1:0]   axis_in_tuser,

  output logic                    axis_out_tvalid,
  input  logic                    axis_out_tready,
  output logic [AXIS_DATAW-1:0]   axis_out_tdata,
  output logic                    axis_out_tlast,
  output logic [AXIS_DESTW-1:0]   axis_out_tdest,
  output logic [AXIS_USERW-1:0]   axis_out_tuser,
  output logic [AXIS_IDW-1:0]     axis_out_tid,
  output logic [AXIS_DATAW/8-1:0] axis_out_tstrb,
  output logic [AXIS_DATAW/8-1:0] axis_out_tkeep,

  output logic [31:0]             pkt_done_count
);

  typedef enum logic {
    ACCUM = 1'b0,
    SEND  = 1'b1
  } state_t;

  state_t                  state_q;
  logic [DATA_WIDTH-1:0]   sum_q;
  logic [CNT_WIDTH-1:0]    cnt_q;
  logic                    ovf_q;
  logic [AXIS_DATAW-1:0]   out_data_q;
  logic [AXIS_DESTW-1:0]   out_dest_q;
  logic [31:0]             pkt_done_q;

  logic [DATA_WIDTH:0]     add_full;
  logic [CNT_WIDTH-1:0]    cnt_inc;
  logic                    ovf_inc;
  logic [AXIS_DATAW-1:0]   result;

  // Payload bits above DATA_WIDTH are intentionally ignored.
  logic unused_tdata;
  assign unused_tdata = ^axis_in_tdata[AXIS_DATAW-1:DATA_WIDTH];

  // Running values as they would be after accepting the current input beat.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch can be inferred.
    result   = '0;
    add_full = {1'b0, sum_q} + {1'b0, axis_in_tdata[DATA_WIDTH-1:0]};
    cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + CNT_WIDTH'(1);
    ovf_inc  = ovf_q | add_full[DATA_WIDTH];
    result[DATA_WIDTH-1:0]              = add_full[DATA_WIDTH-1:0];
    result[DATA_WIDTH +: CNT_WIDTH]     = cnt_inc;
    result[DATA_WIDTH + CNT_WIDTH]      = ovf_inc;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ACCUM;
      sum_q      <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      out_data_q <= '0;
      out_dest_q <= '0;
      pkt_done_q <= '0;
    end else begin
      case (state_q)
        ACCUM: begin
          // tready is unconditionally high in ACCUM, so tvalid alone marks an accepted beat.
          if (axis_in_tvalid) begin
            sum_q <= add_full[DATA_WIDTH-1:0];
            cnt_q <= cnt_inc;
            ovf_q <= ovf_inc;
            if (axis_in_tlast) begin
              out_data_q <= result;
              out_dest_q <= AXIS_DESTW'(axis_in_tuser);
              state_q    <= SEND;
            end
          end
        end
        SEND: begin
          if (axis_out_tready) begin
            sum_q      <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            pkt_done_q <= pkt_done_q + 32'd1;
            state_q    <= ACCUM;
          end
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

  // Handshake outputs depend on state only: no combinational input-to-output path.
  assign axis_in_tready  = (state_q == ACCUM);
  assign axis_out_tvalid = (state_q == SEND);
  assign axis_out_tdata  = out_data_q;
  assign axis_out_tlast  = 1'b1;
  assign axis_out_tdest  = out_dest_q;
  assign axis_out_tuser  = AXIS_USERW'(SRC_ADDR);
  assign axis_out_tid    = '0;
  assign axis_out_tstrb  = '0;
  assign axis_out_tkeep  = '0;
  assign pkt_done_count  = pkt_done_q;

endmodule

// File: tb/tb_axis_accum_adder.sv
// Directed bench for axis_accum_adder: default build plus an 8-bit-sum build and a 2-bit-counter build.
module tb_axis_accum_adder;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_checks;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- default build ----------------
  logic         m_in_valid, m_in_ready, m_in_last;
  logic [511:0] m_in_data;
  logic [11:0]  m_in_user;
  logic         m_out_valid, m_out_ready, m_out_last;
  logic [511:0] m_out_data;
  logic [11:0]  m_out_dest, m_out_user;
  logic [7:0]   m_out_id;
  logic [63:0]  m_out_strb, m_out_keep;
  logic [31:0]  m_pkt;

  axis_accum_adder dut (
    .clk(clk), .rst(rst),
    .axis_in_tvalid(m_in_valid), .axis_in_tready(m_in_ready), .axis_in_tdata(m_in_data),
    .axis_in_tlast(m_in_last), .axis_in_tuser(m_in_user),
    .axis_out_tvalid(m_out_valid), .axis_out_tready(m_out_ready), .axis_out_tdata(m_out_data),
    .axis_out_tlast(m_out_last), .axis_out_tdest(m_out_dest), .axis_out_tuser(m_out_user),
    .axis_out_tid(m_out_id), .axis_out_tstrb(m_out_strb), .axis_out_tkeep(m_out_keep),
    .pkt_done_count(m_pkt)
  );

  // ---------------- DATA_WIDTH=8 build ----------------
  logic         b_in_valid, b_in_ready, b_in_last;
  logic [511:0] b_in_data;
  logic [11:0]  b_in_user;
  logic         b_out_valid, b_out_ready, b_out_last;
  logic [511:0] b_out_data;
  logic [11:0]  b_out_dest, b_out_user;
  logic [7:0]   b_out_id;
  logic [63:0]  b_out_strb, b_out_keep;
  logic [31:0]  b_pkt;

  axis_accum_adder #(.DATA_WIDTH(8)) dut8 (
    .clk(clk), .rst(rst),
    .axis_in_tvalid(b_in_valid), .axis_in_tready(b_in_ready), .axis_in_tdata(b_in_data),
    .axis_in_tlast(b_in_last), .axis_in_tuser(b_in_user),
    .axis_out_tvalid(b_out_valid), .axis_out_tready(b_out_ready), .axis_out_tdata(b_out_data),
    .axis_out_tlast(b_out_last), .axis_out_tdest(b_out_dest), .axis_out_tuser(b_out_user),
    .axis_out_tid(b_out_id), .axis_out_tstrb(b_out_strb), .axis_out_tkeep(b_out_keep),
    .pkt_done_count(b_pkt)
  );

  // ---------------- CNT_WIDTH=2 build ----------------
  logic         c_in_valid, c_in_ready, c_in_last;
  logic [511:0] c_in_data;
  logic [11:0]  c_in_user;
  logic         c_out_valid, c_out_ready, c_out_last;
  logic [511:0] c_out_data;
  logic [11:0]  c_out_dest, c_out_user;
  logic [7:0]   c_out_id;
  logic [63:0]  c_out_strb, c_out_keep;
  logic [31:0]  c_pkt;

  axis_accum_adder #(.CNT_WIDTH(2)) dutc2 (
    .clk(clk), .rst(rst),
    .axis_in_tvalid(c_in_valid), .axis_in_tready(c_in_ready), .axis_in_tdata(c_in_data),
    .axis_in_tlast(c_in_last), .axis_in_tuser(c_in_user),
    .axis_out_tvalid(c_out_valid), .axis_out_tready(c_out_ready), .axis_out_tdata(c_out_data),
    .axis_out_tlast(c_out_last), .axis_out_tdest(c_out_dest), .axis_out_tuser(c_out_user),
    .axis_out_tid(c_out_id), .axis_out_tstrb(c_out_strb), .axis_out_tkeep(c_out_keep),
    .pkt_done_count(c_pkt)
  );

  // Expected result words for each build's field layout.
  function automatic logic [511:0] exp_main(input logic ovf, input logic [15:0] cnt, input logic [127:0] sum);
    logic [511:0] r;
    r = '0; r[127:0] = sum; r[143:128] = cnt; r[144] = ovf;
    return r;
  endfunction

  function automatic logic [511:0] exp_d8(input logic ovf, input logic [15:0] cnt, input logic [7:0] sum);
    logic [511:0] r;
    r = '0; r[7:0] = sum; r[23:8] = cnt; r[24] = ovf;
    return r;
  endfunction

  function automatic logic [511:0] exp_c2(input logic ovf, input logic [1:0] cnt, input logic [127:0] sum);
    logic [511:0] r;
    r = '0; r[127:0] = sum; r[129:128] = cnt; r[130] = ovf;
    return r;
  endfunction

  // Presents one beat on the default build's input; caller advances the clock.
  task automatic drive_beat(input logic [127:0] d, input logic last, input logic [11:0] user);
    m_in_valid = 1'b1;
    m_in_data  = '0;
    m_in_data[127:0] = d;
    m_in_last  = last;
    m_in_user  = user;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (m_in_ready !== 1'b1)  $display("FAIL reset_in_tready: got %b want 1", m_in_ready); else n_pass++;
    n_checks++; if (m_out_valid !== 1'b0) $display("FAIL reset_out_tvalid: got %b want 0", m_out_valid); else n_pass++;
    n_checks++; if (m_out_data !== '0)    $display("FAIL reset_tdata: got %h want 0", m_out_data); else n_pass++;
    n_checks++; if (m_out_dest !== '0)    $display("FAIL reset_tdest: got %h want 0", m_out_dest); else n_pass++;
    n_checks++; if (m_pkt !== 32'd0)      $display("FAIL reset_pkt_done: got %0d want 0", m_pkt); else n_pass++;
    n_checks++; if (m_out_last !== 1'b1)  $display("FAIL reset_tlast: got %b want 1", m_out_last); else n_pass++;
    n_checks++; if (m_out_user !== 12'd0) $display("FAIL reset_tuser: got %h want 0", m_out_user); else n_pass++;
    n_checks++; if ({m_out_id, m_out_strb, m_out_keep} !== '0)
      $display("FAIL reset_id_strb_keep: got %h want 0", {m_out_id, m_out_strb, m_out_keep}); else n_pass++;
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    m_out_ready = 1'b1;
    drive_beat(128'd5, 1'b0, 12'd0); @(negedge clk);
    drive_beat(128'd7, 1'b0, 12'd0); @(negedge clk);
    drive_beat(128'd9, 1'b1, 12'd3);
    n_checks++; if (m_out_valid !== 1'b0) $display("FAIL basic_no_early_valid: got %b want 0", m_out_valid); else n_pass++;
    @(negedge clk);
    m_in_valid = 1'b0; m_in_last = 1'b0;
    n_checks++; if (m_out_valid !== 1'b1) $display("FAIL basic_valid_latency: got %b want 1", m_out_valid); else n_pass++;
    n_checks++; if (m_out_data !== exp_main(1'b0, 16'd3, 128'd21))
      $display("FAIL basic_tdata: got %h want %h", m_out_data, exp_main(1'b0, 16'd3, 128'd21)); else n_pass++;
    n_checks++; if (m_out_dest !== 12'd3) $display("FAIL basic_tdest: got %0d want 3", m_out_dest); else n_pass++;
    n_checks++; if (m_in_ready !== 1'b0)  $display("FAIL basic_in_ready_send: got %b want 0", m_in_ready); else n_pass++;
    @(negedge clk);
    n_checks++; if (m_out_valid !== 1'b0) $display("FAIL basic_valid_drop: got %b want 0", m_out_valid); else n_pass++;
    n_checks++; if (m_in_ready !== 1'b1)  $display("FAIL basic_in_ready_back: got %b want 1", m_in_ready); else n_pass++;
    n_checks++; if (m_pkt !== 32'd1)      $display("FAIL basic_pkt_done: got %0d want 1", m_pkt); else n_pass++;
  endtask

  task automatic test_backpressure();
    int bad_valid, bad_data, bad_ready;
    bad_valid = 0; bad_data = 0; bad_ready = 0;
    m_out_ready = 1'b0;
    drive_beat(128'd20, 1'b0, 12'd0); @(negedge clk);
    drive_beat(128'd22, 1'b1, 12'd5); @(negedge clk);
    // Upstream holds a closing beat during the stall; it must not be absorbed.
    drive_beat(128'd99, 1'b1, 12'd7);
    for (int i = 0; i < 10; i++) begin
      if (m_out_valid !== 1'b1) bad_valid++;
      if (m_out_data !== exp_main(1'b0, 16'd2, 128'd42)) bad_data++;
      if (m_in_ready !== 1'b0) bad_ready++;
      @(negedge clk);
    end
    n_checks++; if (bad_valid != 0) $display("FAIL bp_valid_held: got %0d drops want 0", bad_valid); else n_pass++;
    n_checks++; if (bad_data != 0)  $display("FAIL bp_tdata_stable: got %0d diffs want 0", bad_data); else n_pass++;
    n_checks++; if (bad_ready != 0) $display("FAIL bp_in_ready_low: got %0d highs want 0", bad_ready); else n_pass++;
    n_checks++; if (m_out_dest !== 12'd5) $display("FAIL bp_tdest: got %0d want 5", m_out_dest); else n_pass++;
    m_out_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (m_out_valid !== 1'b0) $display("FAIL bp_release_valid: got %b want 0", m_out_valid); else n_pass++;
    n_checks++; if (m_in_ready !== 1'b1)  $display("FAIL bp_release_in_ready: got %b want 1", m_in_ready); else n_pass++;
    n_checks++; if (m_pkt !== 32'd2)      $display("FAIL bp_pkt_done: got %0d want 2", m_pkt); else n_pass++;
    @(negedge clk);
    m_in_valid = 1'b0; m_in_last = 1'b0;
    n_checks++; if (m_out_data !== exp_main(1'b0, 16'd1, 128'd99))
      $display("FAIL bp_held_beat: got %h want %h", m_out_data, exp_main(1'b0, 16'd1, 128'd99)); else n_pass++;
    n_checks++; if (m_out_dest !== 12'd7) $display("FAIL bp_held_tdest: got %0d want 7", m_out_dest); else n_pass++;
    @(negedge clk);
    n_checks++; if (m_pkt !== 32'd3) $display("FAIL bp_pkt_done2: got %0d want 3", m_pkt); else n_pass++;
  endtask

  task automatic test_back_to_back();
    rst = 1'b0; @(negedge clk);
    rst = 1'b1; @(negedge clk);
    m_out_ready = 1'b1;
    drive_beat(128'd1, 1'b0, 12'd0); @(negedge clk);
    drive_beat(128'd2, 1'b1, 12'd1); @(negedge clk);
    drive_beat(128'd10, 1'b1, 12'd2);
    n_checks++; if (m_out_valid !== 1'b1) $display("FAIL b2b_first_valid: got %b want 1", m_out_valid); else n_pass++;
    n_checks++; if (m_out_data !== exp_main(1'b0, 16'd2, 128'd3))
      $display("FAIL b2b_first_tdata: got %h want %h", m_out_data, exp_main(1'b0, 16'd2, 128'd3)); else n_pass++;
    n_checks++; if (m_out_dest !== 12'd1) $display("FAIL b2b_first_tdest: got %0d want 1", m_out_dest); else n_pass++;
    @(negedge clk);
    n_checks++; if (m_out_valid !== 1'b0) $display("FAIL b2b_gap_valid: got %b want 0", m_out_valid); else n_pass++;
    @(negedge clk);
    m_in_valid = 1'b0; m_in_last = 1'b0;
    n_checks++; if (m_out_data !== exp_main(1'b0, 16'd1, 128'd10))
      $display("FAIL b2b_second_tdata: got %h want %h", m_out_data, exp_main(1'b0, 16'd1, 128'd10)); else n_pass++;
    n_checks++; if (m_out_dest !== 12'd2) $display("FAIL b2b_second_tdest: got %0d want 2", m_out_dest); else n_pass++;
    @(negedge clk);
    n_checks++; if (m_pkt !== 32'd2) $display("FAIL b2b_pkt_done: got %0d want 2", m_pkt); else n_pass++;
  endtask

  task automatic test_reset_mid_packet();
    m_out_ready = 1'b0;
    drive_beat(128'd50, 1'b0, 12'd0); @(negedge clk);
    drive_beat(128'd60, 1'b0, 12'd0); @(negedge clk);
    m_in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    n_checks++; if (m_out_data !== '0) $display("FAIL rstmid_tdata: got %h want 0", m_out_data); else n_pass++;
    n_checks++; if (m_out_dest !== '0) $display("FAIL rstmid_tdest: got %h want 0", m_out_dest); else n_pass++;
    n_checks++; if (m_pkt !== 32'd0)   $display("FAIL rstmid_pkt_done: got %0d want 0", m_pkt); else n_pass++;
    n_checks++; if (m_out_valid !== 1'b0) $display("FAIL rstmid_valid: got %b want 0", m_out_valid); else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    drive_beat(128'd4, 1'b0, 12'd0); @(negedge clk);
    drive_beat(128'd4, 1'b1, 12'd9); @(negedge clk);
    m_in_valid = 1'b0; m_in_last = 1'b0;
    n_checks++; if (m_out_data !== exp_main(1'b0, 16'd2, 128'd8))
      $display("FAIL rstmid_new_pkt: got %h want %h", m_out_data, exp_main(1'b0, 16'd2, 128'd8)); else n_pass++;
    m_out_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (m_pkt !== 32'd1) $display("FAIL rstmid_pkt_after: got %0d want 1", m_pkt); else n_pass++;
  endtask

  task automatic test_overflow_d8();
    b_out_ready = 1'b1;
    b_in_valid  = 1'b1;
    b_in_data   = '0; b_in_data[7:0] = 8'd200; b_in_data[100] = 1'b1;
    b_in_last   = 1'b0; b_in_user = 12'd0;
    @(negedge clk);
    b_in_data = '0; b_in_data[7:0] = 8'd100; b_in_last = 1'b1; b_in_user = 12'd4;
    @(negedge clk);
    n_checks++; if (b_out_valid !== 1'b1) $display("FAIL d8_valid: got %b want 1", b_out_valid); else n_pass++;
    n_checks++; if (b_out_data !== exp_d8(1'b1, 16'd2, 8'd44))
      $display("FAIL d8_overflow_result: got %h want %h", b_out_data, exp_d8(1'b1, 16'd2, 8'd44)); else n_pass++;
    n_checks++; if (b_out_dest !== 12'd4) $display("FAIL d8_tdest: got %0d want 4", b_out_dest); else n_pass++;
    b_in_data = '0; b_in_data[7:0] = 8'd1; b_in_last = 1'b1; b_in_user = 12'd6;
    @(negedge clk);
    @(negedge clk);
    b_in_valid = 1'b0; b_in_last = 1'b0;
    n_checks++; if (b_out_data !== exp_d8(1'b0, 16'd1, 8'd1))
      $display("FAIL d8_ovf_cleared: got %h want %h", b_out_data, exp_d8(1'b0, 16'd1, 8'd1)); else n_pass++;
    @(negedge clk);
    n_checks++; if (b_pkt !== 32'd2) $display("FAIL d8_pkt_done: got %0d want 2", b_pkt); else n_pass++;
  endtask

  task automatic test_count_saturate();
    c_out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      c_in_valid = 1'b1;
      c_in_data  = '0; c_in_data[0] = 1'b1;
      c_in_last  = (i == 4);
      c_in_user  = 12'd2;
      @(negedge clk);
    end
    c_in_valid = 1'b0; c_in_last = 1'b0;
    n_checks++; if (c_out_valid !== 1'b1) $display("FAIL c2_valid: got %b want 1", c_out_valid); else n_pass++;
    n_checks++; if (c_out_data !== exp_c2(1'b0, 2'd3, 128'd5))
      $display("FAIL c2_saturate: got %h want %h", c_out_data, exp_c2(1'b0, 2'd3, 128'd5)); else n_pass++;
    @(negedge clk);
    n_checks++; if (c_pkt !== 32'd1) $display("FAIL c2_pkt_done: got %0d want 1", c_pkt); else n_pass++;
  endtask

  initial begin
    n_pass = 0; n_checks = 0;
    rst = 1'b0;
    m_in_valid = 1'b0; m_in_data = '0; m_in_last = 1'b0; m_in_user = '0; m_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_data = '0; b_in_last = 1'b0; b_in_user = '0; b_out_ready = 1'b0;
    c_in_valid = 1'b0; c_in_data = '0; c_in_last = 1'b0; c_in_user = '0; c_out_ready = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_packet();
    test_overflow_d8();
    test_count_saturate();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
